// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// A 32-iteration restoring divider works on magnitudes. It holds BUSY to stall
// the pipeline while it runs, then presents a signed-corrected result for one
// cycle with DONE. Divide-by-zero and signed overflow skip the iterations and
// finish one cycle after accept.
module div_sequencer (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [5:0]  ALU_SIGNAL,
   input  logic [31:0] OPERAND_A,
   input  logic [31:0] OPERAND_B,
   input  logic        FLUSH,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RESULT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t      state, state_nxt;

   // latched operation context
   logic        op_rem;      // 1: remainder result, 0: quotient result
   logic        op_sgn;      // signed op (DIV/REM)
   logic        neg_q;
   logic        neg_r;
   logic        special;     // result preloaded, no sign fix
   logic [31:0] dvd;         // dividend magnitude, shifted out MSB first
   logic [31:0] dvs;         // divisor magnitude
   logic [31:0] quo;
   logic [31:0] rem;
   logic [4:0]  cnt;

   // decode of the incoming instruction
   logic        is_div;
   logic        in_sgn;
   logic        div_zero;
   logic        ovf;
   logic        accept;
   logic [31:0] abs_a;
   logic [31:0] abs_b;

   // one restoring step
   logic [32:0] trial;
   logic        q_bit;
   logic [31:0] rem_nxt;

   // final result shaping
   logic [31:0] sel_res;
   logic        fix_sign;
   logic [31:0] fin_res;

   assign is_div   = (ALU_SIGNAL[5:2] == 4'b0011);
   assign in_sgn   = ~ALU_SIGNAL[0];
   assign div_zero = (OPERAND_B == 32'h0);
   assign ovf      = in_sgn & (OPERAND_A == 32'h8000_0000) & (OPERAND_B == 32'hFFFF_FFFF);
   // reset gates accept so BUSY stays low while the block is held in reset
   assign accept   = RESET & START & is_div & ~FLUSH & (state == IDLE);

   // magnitudes for signed ops; 0x80000000 maps to itself, correct as unsigned
   assign abs_a = (in_sgn & OPERAND_A[31]) ? (32'h0 - OPERAND_A) : OPERAND_A;
   assign abs_b = (in_sgn & OPERAND_B[31]) ? (32'h0 - OPERAND_B) : OPERAND_B;

   // partial remainder stays below the divisor, so the trial fits in 33 bits
   assign trial   = {rem, dvd[31]} - {1'b0, dvs};
   assign q_bit   = ~trial[32];
   assign rem_nxt = q_bit ? trial[31:0] : {rem[30:0], dvd[31]};

   assign sel_res  = op_rem ? rem : quo;
   assign fix_sign = ~special & op_sgn & (op_rem ? neg_r : neg_q);
   assign fin_res  = fix_sign ? (32'h0 - sel_res) : sel_res;

   // state register; reset wins over everything
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and the stall/result outputs
   always_comb begin
      state_nxt = state;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      RESULT    = 32'h0;
      case (state)
         IDLE: begin
            if (accept) begin
               BUSY      = 1'b1;
               state_nxt = (div_zero | ovf) ? FIN : CALC;
            end
         end
         CALC: begin
            BUSY = 1'b1;
            if (cnt == 5'd31) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            DONE      = 1'b1;
            RESULT    = fin_res;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (FLUSH) begin
         state_nxt = IDLE;
      end
   end

   // datapath: latch operands on accept, iterate one quotient bit per CALC cycle
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         op_rem  <= 1'b0;
         op_sgn  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         special <= 1'b0;
         dvd     <= 32'h0;
         dvs     <= 32'h0;
         quo     <= 32'h0;
         rem     <= 32'h0;
         cnt     <= 5'd0;
      end else if (accept) begin
         op_rem  <= ALU_SIGNAL[1];
         op_sgn  <= in_sgn;
         neg_q   <= in_sgn & (OPERAND_A[31] ^ OPERAND_B[31]);
         neg_r   <= in_sgn & OPERAND_A[31];
         special <= div_zero | ovf;
         dvd     <= abs_a;
         dvs     <= abs_b;
         cnt     <= 5'd0;
         if (div_zero) begin
            quo <= 32'hFFFF_FFFF;
            rem <= OPERAND_A;
         end else if (ovf) begin
            quo <= 32'h8000_0000;
            rem <= 32'h0;
         end else begin
            quo <= 32'h0;
            rem <= 32'h0;
         end
      end else if (state == CALC) begin
         rem <= rem_nxt;
         quo <= {quo[30:0], q_bit};
         dvd <= {dvd[30:0], 1'b0};
         cnt <= cnt + 5'd1;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed literal cases plus randomized ops, checked
// every cycle against a cycle-level model whose results come from plain
// arithmetic on the operands.
module tb_div_sequencer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        START = 1'b0;
   logic [5:0]  ALU_SIGNAL = 6'h0;
   logic [31:0] OPERAND_A = 32'h0;
   logic [31:0] OPERAND_B = 32'h0;
   logic        FLUSH = 1'b0;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   localparam logic [5:0] OP_DIV  = 6'b001100;
   localparam logic [5:0] OP_DIVU = 6'b001101;
   localparam logic [5:0] OP_REM  = 6'b001110;
   localparam logic [5:0] OP_REMU = 6'b001111;

   int   nerr = 0;
   int   nchk = 0;
   logic chk_en = 1'b0;

   always #5 CLK = ~CLK;

   div_sequencer dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .START      (START),
      .ALU_SIGNAL (ALU_SIGNAL),
      .OPERAND_A  (OPERAND_A),
      .OPERAND_B  (OPERAND_B),
      .FLUSH      (FLUSH),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .RESULT     (RESULT)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic is_divop(input logic [5:0] s);
      return s[5:2] == 4'b0011;
   endfunction

   function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // RV32M semantics straight from the instruction definitions
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
         sa = a;
         sb = b;
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   // cycle-level model: m_wait counts remaining iteration cycles, m_fin marks the result cycle
   int          m_wait = 0;
   logic        m_fin = 1'b0;
   logic [31:0] m_res = 32'h0;

   always @(posedge CLK) begin
      if (!RESET || FLUSH) begin
         m_wait <= 0;
         m_fin  <= 1'b0;
      end else if (m_fin) begin
         m_fin <= 1'b0;
      end else if (m_wait > 0) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) m_fin <= 1'b1;
      end else if (START && is_divop(ALU_SIGNAL)) begin
         m_res <= ref_result(ALU_SIGNAL[1:0], OPERAND_A, OPERAND_B);
         if (is_special(ALU_SIGNAL[1:0], OPERAND_A, OPERAND_B)) m_fin <= 1'b1;
         else m_wait <= 32;
      end
   end

   // every-cycle comparison against the model
   always @(negedge CLK) begin
      logic e_busy;
      if (chk_en) begin
         if (m_fin)          e_busy = 1'b0;
         else if (m_wait > 0) e_busy = 1'b1;
         else                e_busy = RESET && START && is_divop(ALU_SIGNAL) && !FLUSH;
         check("busy", {31'h0, BUSY}, {31'h0, e_busy});
         check("done", {31'h0, DONE}, {31'h0, m_fin});
         check("result", RESULT, m_fin ? m_res : 32'h0);
      end
   end

   // Drive one instruction into EX (caller sits just after a rising edge).
   // fl_at >= 1 flushes the instruction in cycle T+fl_at; returns DONE latency
   // (-1 if none), result and BUSY cycle count.
   task automatic run(input logic [5:0] alu, input logic [31:0] a, input logic [31:0] b,
                      input int fl_at, output int lat, output logic [31:0] res, output int bc);
      lat = -1;
      res = 32'h0;
      bc  = 0;
      START = 1'b1;
      ALU_SIGNAL = alu;
      OPERAND_A = a;
      OPERAND_B = b;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (BUSY) bc++;
         if (DONE && lat < 0) begin
            lat = i;
            res = RESULT;
         end
         @(posedge CLK);
         #1;
         FLUSH = 1'b0;
         if (lat >= 0) break;
         if (fl_at >= 0 && i >= fl_at) break;
         if (i + 1 == fl_at) begin
            FLUSH = 1'b1;
            START = 1'b0;
         end
      end
      START = 1'b0;
      FLUSH = 1'b0;
   endtask

   task automatic quiet(input int n, input string nm);
      int dn;
      int bz;
      dn = 0;
      bz = 0;
      repeat (n) begin
         @(negedge CLK);
         if (DONE) dn++;
         if (BUSY) bz++;
      end
      check({nm, "_no_done"}, 32'(dn), 32'h0);
      check({nm, "_no_busy"}, 32'(bz), 32'h0);
      @(posedge CLK);
      #1;
   endtask

   task automatic pick(output logic [31:0] v, input logic is_b);
      case ($urandom_range(0, 6))
         0: v = 32'h0;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = $urandom_range(0, 20);
         4: v = is_b ? (32'h0 - 32'($urandom_range(1, 9))) : 32'($urandom_range(0, 1000));
         default: v = $urandom;
      endcase
   endtask

   initial begin
      int          lat;
      int          bc;
      logic [31:0] res;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  alu;
      int          fl;
      int          d;
      int          bz;

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      chk_en = 1'b1;
      @(negedge CLK);
      check("rst_busy", {31'h0, BUSY}, 32'h0);
      check("rst_done", {31'h0, DONE}, 32'h0);
      check("rst_result", RESULT, 32'h0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;

      // DIV 100 / 7: 33 stall cycles, result at T+33, zero afterwards
      run(OP_DIV, 32'd100, 32'd7, -1, lat, res, bc);
      check("div100_7_lat", 32'(lat), 32'd33);
      check("div100_7_busy", 32'(bc), 32'd33);
      check("div100_7_res", res, 32'd14);
      @(negedge CLK);
      check("div100_7_after", RESULT, 32'h0);
      @(posedge CLK);
      #1;

      // signed/unsigned results, back to back
      run(OP_REM, 32'hFFFF_FFF9, 32'd2, -1, lat, res, bc);
      check("rem_m7_2", res, 32'hFFFF_FFFF);
      run(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, lat, res, bc);
      check("div_m7_2", res, 32'hFFFF_FFFD);
      check("div_m7_2_lat", 32'(lat), 32'd33);
      run(OP_DIVU, 32'hFFFF_FFFF, 32'd2, -1, lat, res, bc);
      check("divu_max_2", res, 32'h7FFF_FFFF);

      // special cases finish one cycle after accept
      run(OP_DIVU, 32'd5, 32'd0, -1, lat, res, bc);
      check("divu_5_0", res, 32'hFFFF_FFFF);
      check("divu_5_0_lat", 32'(lat), 32'd1);
      check("divu_5_0_busy", 32'(bc), 32'd1);
      run(OP_REMU, 32'd5, 32'd0, -1, lat, res, bc);
      check("remu_5_0", res, 32'd5);
      check("remu_5_0_busy", 32'(bc), 32'd1);
      run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, res, bc);
      check("div_ovf", res, 32'h8000_0000);
      check("div_ovf_lat", 32'(lat), 32'd1);
      run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, res, bc);
      check("rem_ovf", res, 32'h0);
      check("rem_ovf_busy", 32'(bc), 32'd1);

      // flush mid-calculation
      run(OP_DIV, 32'd1000, 32'd3, 10, lat, res, bc);
      check("flush_lat", 32'(lat), 32'hFFFF_FFFF);
      quiet(40, "flush");
      run(OP_DIVU, 32'd9, 32'd3, -1, lat, res, bc);
      check("post_flush_res", res, 32'd3);
      check("post_flush_lat", 32'(lat), 32'd33);

      // reset mid-calculation at T+5
      START = 1'b1;
      ALU_SIGNAL = OP_DIV;
      OPERAND_A = 32'd1000;
      OPERAND_B = 32'd3;
      repeat (5) @(posedge CLK);
      #1;
      RESET = 1'b0;
      START = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(negedge CLK);
      check("mid_rst_busy", {31'h0, BUSY}, 32'h0);
      check("mid_rst_done", {31'h0, DONE}, 32'h0);
      check("mid_rst_result", RESULT, 32'h0);
      @(posedge CLK);
      #1;
      quiet(40, "mid_rst");
      run(OP_REM, 32'd10, 32'd4, -1, lat, res, bc);
      check("post_rst_rem", res, 32'd2);
      check("post_rst_lat", 32'(lat), 32'd33);

      // MUL is not ours: no stall, no strobe
      START = 1'b1;
      ALU_SIGNAL = 6'b001000;
      d = 0;
      bz = 0;
      repeat (5) begin
         @(negedge CLK);
         if (DONE) d++;
         if (BUSY) bz++;
      end
      check("mul_busy", 32'(bz), 32'h0);
      check("mul_done", 32'(d), 32'h0);
      @(posedge CLK);
      #1;
      START = 1'b0;

      // randomized ops, flushes, foreign instructions and gaps
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            do alu = 6'($urandom); while (alu[5:2] == 4'b0011);
            START = 1'b1;
            ALU_SIGNAL = alu;
            OPERAND_A = $urandom;
            OPERAND_B = $urandom;
            repeat ($urandom_range(1, 4)) @(posedge CLK);
            #1;
            START = 1'b0;
         end else begin
            alu = {4'b0011, 2'($urandom_range(0, 3))};
            pick(a, 1'b0);
            pick(b, 1'b1);
            fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 34) : -1;
            run(alu, a, b, fl, lat, res, bc);
            if (lat >= 0) check("rand_res", res, ref_result(alu[1:0], a, b));
            if (fl < 0) check("rand_lat", 32'(lat), is_special(alu[1:0], a, b) ? 32'd1 : 32'd33);
         end
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
         end
      end

      repeat (3) @(posedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
      $fatal(1);
   end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the RV32M divide/remainder group (DIV, DIVU, REM, REMU) in the EX stage. The single-cycle ALU handles every other ALU_SIGNAL, including MUL*. This block runs a 32-iteration restoring division on register-held operands. It holds a stall request to the hazard logic while it works, then presents the result for exactly one cycle so the EX/MEM register captures it.

## Interface
- No parameters. Data width is fixed at 32.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset (0 = reset).
- START  in  1  ID/EX holds a valid instruction. Held high every cycle that instruction sits in EX, including stalled cycles.
- ALU_SIGNAL  in  6  decoded ALU control from ID/EX. Divide op when ALU_SIGNAL[5:2] == 4'b0011; ALU_SIGNAL[1:0] selects 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- OPERAND_A  in  32  dividend (rs1), stable while START high.
- OPERAND_B  in  32  divisor (rs2), stable while START high.
- FLUSH  in  1  branch/jump flush of EX; aborts any operation.
- BUSY  out  1  stall request. Freezes PC, IF/ID and ID/EX.
- DONE  out  1  one-cycle result-valid strobe.
- RESULT  out  32  quotient or remainder; valid only while DONE = 1, otherwise 0.

## Operation
- States: IDLE, CALC, FIN.
- Accept condition: state == IDLE & START & divide op & ~FLUSH.
- On accept, latch:
  - op type;
  - |A| and |B| for signed ops, raw values for unsigned ops;
  - neg_q = A[31]^B[31] and neg_r = A[31] (signed ops only);
  - quotient register cleared, remainder register cleared, count = 0.
- Special cases are detected at accept and go straight to FIN with the result preloaded:
  - B == 0: quotient = 32'hFFFFFFFF, remainder = A (unmodified).
  - Signed overflow (A == 32'h80000000, B == 32'hFFFFFFFF, DIV/REM only): quotient = 32'h80000000, remainder = 0.
- Normal accept goes to CALC.
- CALC, one iteration per cycle:
  - t = {rem[31:0], dvd[31]} − {1'b0, div} (33-bit).
  - If t[32] == 0: rem = t[31:0], q bit = 1; else rem = {rem[30:0], dvd[31]}, q bit = 0.
  - dvd shifts left; q shifts left with the new bit in.
  - count increments; after the count == 31 iteration, go to FIN.
- FIN:
  - RESULT = quotient (DIV/DIVU) or remainder (REM/REMU).
  - Signed ops: negate quotient when neg_q, negate remainder when neg_r.
  - Special-case results are output as latched, with no sign fix.
  - DONE = 1, BUSY = 0. Next state is IDLE unconditionally.
  - START is still high in FIN for the same instruction and must not be re-accepted; ID/EX advances at the end of the FIN cycle.
- Non-divide ALU_SIGNAL with START: the block stays IDLE, BUSY = 0, DONE = 0.
- FLUSH = 1 (RESET deasserted): next state IDLE from any state; no DONE is ever produced for the aborted op. DONE/RESULT in the cycle FLUSH is asserted are still driven by the current state.
- RESET = 0: next state IDLE, count = 0, all datapath registers = 0. Takes priority over FLUSH and START, including mid-CALC.

## Timing
- Reset values: state IDLE, BUSY 0, DONE 0, RESULT 32'h0.
- BUSY is combinational: (IDLE & accept condition) | CALC. It rises in the accept cycle T so the pipeline never advances past the divide.
- Normal op:
  - accept at T, CALC in T+1..T+32, FIN at T+33.
  - BUSY high T..T+32 (33 cycles); DONE high only at T+33.
  - Total EX occupancy is 34 cycles.
- Special case: accept at T, FIN at T+1. BUSY high at T only; DONE at T+1.
- Back-to-back divides: the earliest next accept is the cycle after FIN (IDLE).
- FLUSH at cycle F during CALC: IDLE at F+1, BUSY low from F+1.
- DONE is never high two consecutive cycles.

## Test plan
- DIV 100 / 7, START held: BUSY high 33 cycles from T; DONE only at T+33 with RESULT = 14; RESULT = 0 at T+34.
- REM −7 / 2 → RESULT 32'hFFFFFFFF (−1). DIV −7 / 2 → 32'hFFFFFFFD (−3). DIVU 32'hFFFFFFFF / 2 → 32'h7FFFFFFF.
- DIVU 5 / 0 → DONE at T+1, RESULT 32'hFFFFFFFF. REMU 5 / 0 → 5. DIV 32'h80000000 / −1 → 32'h80000000. REM with the same operands → 0. BUSY high one cycle in each case.
- FLUSH at T+10 of DIV 1000 / 3: BUSY 0 from T+11; no DONE within 40 cycles. A new DIVU 9 / 3 started afterwards returns 3 with normal latency.
- RESET low at T+5 mid-CALC: from T+6, BUSY/DONE/RESULT = 0 and state IDLE. A subsequent REM 10 / 4 → 2.
- ALU_SIGNAL 6'b001000 (MUL) with START high for 5 cycles: BUSY and DONE stay 0 throughout.
